// File: rtl/coin_acceptor.sv
// Coin mech front end: synchronises and debounces the nickel/dime sensors, emits one-cycle
// accept strobes, rejects simultaneous coins, flags stuck sensors and keeps audit counts.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1024,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nickel_raw,
  input  logic             dime_raw,
  output logic             N,
  output logic             D,
  output logic             coin_err,
  output logic             stuck,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt
);

  localparam int unsigned DcW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ScW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DcW-1:0]   DcLast = DcW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ScW-1:0]   ScMax  = ScW'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Channel 0 is the nickel sensor, channel 1 the dime sensor.
  logic [1:0]          raw;
  logic [1:0]          s1_q, s2_q;
  logic [1:0]          db_q, db_d;
  logic [1:0][DcW-1:0] dc_q, dc_d;
  logic [1:0][ScW-1:0] sc_q, sc_d;
  logic [1:0]          rise;

  logic             n_q, n_d;
  logic             d_q, d_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] nickel_cnt_q, nickel_cnt_d;
  logic [CNT_W-1:0] dime_cnt_q, dime_cnt_d;

  assign raw = {dime_raw, nickel_raw};

  always_comb begin
    db_d = db_q;
    dc_d = '0;
    sc_d = '0;
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (dc_q[i] == DcLast) begin
          db_d[i] = s2_q[i];
          rise[i] = s2_q[i];
        end else begin
          dc_d[i] = dc_q[i] + DcW'(1);
        end
      end
      if (db_q[i]) begin
        sc_d[i] = (sc_q[i] == ScMax) ? sc_q[i] : sc_q[i] + ScW'(1);
      end
    end
  end

  // A coin rises together with the other channel is ambiguous: reject both.
  always_comb begin
    n_d          = rise[0] & ~rise[1];
    d_d          = rise[1] & ~rise[0];
    err_d        = rise[0] & rise[1];
    nickel_cnt_d = (n_q && nickel_cnt_q != CntMax) ? nickel_cnt_q + CNT_W'(1) : nickel_cnt_q;
    dime_cnt_d   = (d_q && dime_cnt_q != CntMax) ? dime_cnt_q + CNT_W'(1) : dime_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      db_q         <= '0;
      dc_q         <= '0;
      sc_q         <= '0;
      n_q          <= 1'b0;
      d_q          <= 1'b0;
      err_q        <= 1'b0;
      nickel_cnt_q <= '0;
      dime_cnt_q   <= '0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      db_q         <= db_d;
      dc_q         <= dc_d;
      sc_q         <= sc_d;
      n_q          <= n_d;
      d_q          <= d_d;
      err_q        <= err_d;
      nickel_cnt_q <= nickel_cnt_d;
      dime_cnt_q   <= dime_cnt_d;
    end
  end

  assign N          = n_q;
  assign D          = d_q;
  assign coin_err   = err_q;
  assign stuck      = (sc_q[0] == ScMax) | (sc_q[1] == ScMax);
  assign nickel_cnt = nickel_cnt_q;
  assign dime_cnt   = dime_cnt_q;

endmodule
